// File: rtl/multicycle_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_pkg
// Shared encodings for the multicycle control unit. It holds the state codes,
// the RISC-V major opcodes, and the datapath mux select codes for ALU A, ALU B
// and write-back. It also provides one helper, is_exec_op(), which reports
// whether an opcode has an EXEC step.
// ---------------------------------------------------------------------------
package multicycle_control_unit_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_ARITHMETIC     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ARITHMETIC_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD           = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE          = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH         = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL            = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR           = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_ECALL          = 7'b1110011;

    localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
    localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b10;

    localparam logic [SEL_W-1:0] SRC_B_RS2    = 2'b00;
    localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'b10;

    localparam logic [SEL_W-1:0] WB_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] WB_MDR       = 2'b01;
    localparam logic [SEL_W-1:0] WB_PC        = 2'b10;

    // Opcodes that proceed from DECODE into EXEC (everything defined except ECALL)
    function automatic logic is_exec_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ARITHMETIC, OP_ARITHMETIC_IMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_next_state.sv
// ---------------------------------------------------------------------------
// control_next_state
// Purely combinational next-state logic for the multicycle control unit.
// Ports:
//   i_state      current state
//   i_opcode     IR[6:0]
//   i_halt_req   ECALL-with-exit flag from the datapath; only used in DECODE
//   i_mem_ready  effective memory-ready (already forced high when waits are off)
//   o_next_state state for the next clock edge
// ---------------------------------------------------------------------------
module control_next_state
    import multicycle_control_unit_pkg::*;
(
    input  state_t                i_state,
    input  logic [OPCODE_W-1:0]   i_opcode,
    input  logic                  i_halt_req,
    input  logic                  i_mem_ready,
    output state_t                o_next_state
);

    always_comb begin
        o_next_state = i_state;
        case (i_state)
            ST_FETCH: begin
                if (i_mem_ready) o_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                // Undefined opcodes fall back to FETCH and behave as a NOP
                if (i_opcode == OP_ECALL)
                    o_next_state = i_halt_req ? ST_HALT : ST_FETCH;
                else if (is_exec_op(i_opcode))
                    o_next_state = ST_EXEC;
                else
                    o_next_state = ST_FETCH;
            end
            ST_EXEC: begin
                case (i_opcode)
                    OP_ARITHMETIC, OP_ARITHMETIC_IMM: o_next_state = ST_WB;
                    OP_LOAD, OP_STORE:                o_next_state = ST_MEM;
                    default:                          o_next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (i_mem_ready)
                    o_next_state = (i_opcode == OP_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB:   o_next_state = ST_FETCH;
            ST_HALT: o_next_state = ST_HALT;
            default: o_next_state = ST_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Control FSM for a multicycle RV32I datapath. The state register is the only
// storage in the block. All control outputs are decoded combinationally from
// the state, opcode, bcond and mem_ready.
//
// Build option: MEM_WAIT_EN
//   defined   -> FETCH and MEM stall until mem_ready
//   undefined -> mem_ready is ignored (single-cycle memory)
//
// Ports:
//   clk, reset                rising-edge clock, async active-high reset
//   opcode, bcond, halt_req   IR[6:0], branch result, ECALL exit flag
//   mem_ready                 memory access completes this cycle
//   pc_write .. reg_write     write/strobe enables
//   i_or_d                    memory address select (0 PC, 1 ALUOut)
//   alu_src_a, alu_src_b      ALU operand selects
//   pc_source                 next-PC select (0 ALU result, 1 ALUOut)
//   wb_src                    register write-back select
//   alu_opcode                ALUOp for the ALU control unit
//   is_halted, state          halt flag and current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 bcond,
    input  logic                 halt_req,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 i_or_d,
    output logic [SEL_W-1:0]     alu_src_a,
    output logic [SEL_W-1:0]     alu_src_b,
    output logic                 pc_source,
    output logic [SEL_W-1:0]     wb_src,
    output logic [OPCODE_W-1:0]  alu_opcode,
    output logic                 is_halted,
    output logic [STATE_W-1:0]   state
);

    state_t r_state;
    state_t w_next_state;
    logic   w_mem_ready;

`ifdef MEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    // Single-cycle memory: every access completes, mem_ready has no effect
    assign w_mem_ready = 1'b1 | mem_ready;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    control_next_state u_next_state (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_halt_req   (halt_req),
        .i_mem_ready  (w_mem_ready),
        .o_next_state (w_next_state)
    );

    // Output decode. It is gated by reset so that no write or strobe can fire
    // while reset is held, even though FETCH would otherwise be Mealy on mem_ready.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        pc_source  = 1'b0;
        wb_src     = WB_ALUOUT;
        alu_opcode = OP_LOAD;
        is_halted  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    if (w_mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_DECODE: begin
                    // Precompute the branch/JAL target into ALUOut
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                end
                ST_EXEC: begin
                    alu_opcode = opcode;
                    case (opcode)
                        OP_ARITHMETIC: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_RS2;
                        end
                        OP_ARITHMETIC_IMM, OP_LOAD, OP_STORE: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                        end
                        OP_BRANCH: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_RS2;
                            pc_write  = bcond;
                            pc_source = 1'b1;
                        end
                        OP_JAL: begin
                            reg_write = 1'b1;
                            wb_src    = WB_PC;
                            pc_write  = 1'b1;
                            pc_source = 1'b1;
                        end
                        OP_JALR: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                            pc_write  = 1'b1;
                            reg_write = 1'b1;
                            wb_src    = WB_PC;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    i_or_d = 1'b1;
                    if (opcode == OP_LOAD) mem_read  = 1'b1;
                    else                   mem_write = 1'b1;
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    wb_src    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
                end
                ST_HALT: is_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = r_state;

endmodule
